// File: rtl/alu_arb.sv
`timescale 1ns/1ps
// alu_arb: two-requester round-robin arbiter in front of a shared
// combinational ALU. An accepted operation goes IDLE -> EXEC -> RESP.
// The response is held in RESP until the consumer takes it.
// Optional feature: define ALU_ARB_STATS_EN to add the saturating
// per-requester grant counters gnt_cnt0 and gnt_cnt1.
module alu_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req0_ctrl,
  input  logic [2:0] req1_ctrl,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  output logic       alu_go,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  output logic       rsp_car,
  output logic       rsp_of,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1,
`endif
  input  logic       rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;
  logic   rr_ptr;
  logic   owner;
  logic   grant0;
  logic   grant1;
  logic   grant_any;

  // A lone valid requester always wins; on contention rr_ptr decides.
  assign grant0    = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1    = req1_valid & (~req0_valid |  rr_ptr);
  assign grant_any = (state == IDLE) & (grant0 | grant1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the grant cycle is always an IDLE cycle, so the
  // cycle that takes the response can never also grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs: ready only in IDLE for the granted requester.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
  end

  // Priority pointer moves to the loser on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant_any) begin
      rr_ptr <= grant0;
    end
  end

  // Latch the winning operation; ALU operands keep their value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_ctrl <= 3'd0;
      owner    <= 1'b0;
    end else if (grant_any) begin
      alu_a    <= grant1 ? req1_a    : req0_a;
      alu_b    <= grant1 ? req1_b    : req0_b;
      alu_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
      owner    <= grant1;
    end
  end

  // alu_go is high exactly for the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_go <= 1'b0;
    end else begin
      alu_go <= grant_any;
    end
  end

  // Capture ALU results at the end of EXEC and hold them through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= 4'd0;
      rsp_car   <= 1'b0;
      rsp_of    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= owner;
      rsp_res   <= alu_res;
      rsp_car   <= alu_car;
      rsp_of    <= alu_of;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else if (grant_any) begin
      if (grant0 && (gnt_cnt0 != 8'hff)) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (grant1 && (gnt_cnt1 != 8'hff)) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb.sv
`timescale 1ns/1ps
// tb_alu_arb: directed, table-driven bench for alu_arb with a small
// combinational ALU model (000 add, 001 sub, 010 and, 011 or, else xor).
module tb_alu_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_ctrl, req1_ctrl;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_ctrl;
  logic       alu_go;
  logic [3:0] alu_res;
  logic       alu_car, alu_of;
  logic       rsp_valid, rsp_id;
  logic [3:0] rsp_res;
  logic       rsp_car, rsp_of;
  logic       rsp_ready;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_go(alu_go),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_car(rsp_car), .rsp_of(rsp_of),
`ifdef ALU_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .rsp_ready(rsp_ready)
  );

  // Shared ALU model.
  logic [4:0] sum5;
  always_comb begin
    sum5    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res = 4'd0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_res = sum5[3:0];
        alu_car = sum5[4];
        alu_of  = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
      end
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic       who;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] ctrl;
    logic [3:0] res;
    logic       car;
    logic       of;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive(input logic who, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] ctrl);
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int last_cyc;
    vecs[0] = '{1'b0, 4'd3,  4'd4,  3'b000, 4'd7,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd7,  4'd1,  3'b000, 4'd8,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 4'd15, 4'd1,  3'b000, 4'd0,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd8,  4'd8,  3'b000, 4'd0,  1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd5,  4'd3,  3'b001, 4'd2,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd12, 4'd10, 3'b010, 4'd8,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'd12, 4'd3,  3'b011, 4'd15, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'd6,  4'd5,  3'b100, 4'd3,  1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_ctrl = 0; req1_ctrl = 0;
    repeat (2) @(negedge clk);
    chk("rst_alu_go", alu_go, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_flags", {rsp_car, rsp_of}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operations from the vector table.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      #1;
      chk($sformatf("v%0d_ready", i), vecs[i].who ? req1_ready : req0_ready, 1);
      chk($sformatf("v%0d_other_ready", i), vecs[i].who ? req0_ready : req1_ready, 0);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      chk($sformatf("v%0d_exec_go", i), alu_go, 1);
      chk($sformatf("v%0d_exec_ops", i), {alu_a, alu_b, alu_ctrl},
          {vecs[i].a, vecs[i].b, vecs[i].ctrl});
      chk($sformatf("v%0d_exec_rsp_valid", i), rsp_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].who);
      chk($sformatf("v%0d_rsp_res", i), rsp_res, vecs[i].res);
      chk($sformatf("v%0d_rsp_car", i), rsp_car, vecs[i].car);
      chk($sformatf("v%0d_rsp_of", i), rsp_of, vecs[i].of);
      chk($sformatf("v%0d_resp_go", i), alu_go, 0);
      chk($sformatf("v%0d_hold_a", i), alu_a, vecs[i].a);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      #1;
      chk($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
    end

    // Contention: last grant went to 1, so the pointer favours 0 first.
    drive(1'b0, 4'd1, 4'd1, 3'b000);
    drive(1'b1, 4'd2, 4'd2, 3'b000);
    rsp_ready = 1;
    grants = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk($sformatf("cont%0d_one", grants), req0_ready & req1_ready, 0);
        chk($sformatf("cont%0d_who", grants), req1_ready, grants % 2);
        if (grants > 0) chk($sformatf("cont%0d_gap", grants), cyc - last_cyc, 3);
        last_cyc = cyc;
        grants++;
      end
      @(negedge clk);
    end
    if (grants < 4) chk("cont_timeout", grants, 4);
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(negedge clk);
    rsp_ready = 0;

    // Backpressure: req1 waits while a req0 response is held.
    drive(1'b0, 4'd2, 4'd2, 3'b000);
    #1;
    chk("bp_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    drive(1'b1, 4'd1, 4'd1, 3'b000);
    #1;
    chk("bp_exec_ready1", req1_ready, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_hold", k), {rsp_valid, rsp_id, rsp_res, rsp_car, rsp_of},
          {1'b1, 1'b0, 4'd4, 1'b0, 1'b0});
      chk($sformatf("bp%0d_ready1", k), req1_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    chk("bp_take_ready1", req1_ready, 0);
    @(negedge clk);
    rsp_ready = 0;
    #1;
    chk("bp_next_ready1", req1_ready, 1);
    chk("bp_rsp_cleared", rsp_valid, 0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    chk("bp_rsp1", {rsp_valid, rsp_id, rsp_res}, {1'b1, 1'b1, 4'd2});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Reset mid-operation: a req0 grant leaves the pointer on 1 first.
    drive(1'b0, 4'd9, 4'd3, 3'b001);
    #1;
    chk("rx_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk("rx_exec_go", alu_go, 1);
    rst_n = 0;
    #1;
    chk("rx_alu_go", alu_go, 0);
    chk("rx_alu_ops", {alu_a, alu_b, alu_ctrl}, 0);
    chk("rx_rsp", {rsp_valid, rsp_id, rsp_res, rsp_car, rsp_of}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rx%0d_no_rsp", k), rsp_valid, 0);
      chk($sformatf("rx%0d_no_go", k), alu_go, 0);
      @(negedge clk);
    end
    drive(1'b0, 4'd1, 4'd2, 3'b000);
    drive(1'b1, 4'd5, 4'd5, 3'b000);
    #1;
    chk("rx_first_ready0", req0_ready, 1);
    chk("rx_first_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("rx_rsp0", {rsp_valid, rsp_id, rsp_res}, {1'b1, 1'b0, 4'd3});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

`ifdef ALU_ARB_STATS_EN
    // Counters restarted at reset; one grant to 0 since then.
    chk("st_pre_cnt0", gnt_cnt0, 1);
    chk("st_pre_cnt1", gnt_cnt1, 0);
    req0_valid = 1;
    rsp_ready = 1;
    grants = 0;
    for (int cyc = 0; cyc < 1200 && grants < 300; cyc++) begin
      #1;
      if (req0_ready) grants++;
      @(negedge clk);
    end
    req0_valid = 0;
    repeat (3) @(negedge clk);
    rsp_ready = 0;
    chk("st_grants", grants, 300);
    chk("st_cnt0_sat", gnt_cnt0, 255);
    chk("st_cnt1", gnt_cnt1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-004 SHALL: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-005 SHALL: req0_a, req0_b, req1_a, req1_b  input  4  operands.
REQ-006 SHALL: req0_ctrl / req1_ctrl  input  3  opcode; passed through unmodified.
REQ-007 SHALL: alu_a, alu_b  output  4  operands driven to the shared ALU.
REQ-008 SHALL: alu_ctrl  output  3  opcode driven to the shared ALU.
REQ-009 SHALL: alu_go  output  1  high while the shared ALU is in use.
REQ-010 SHALL: alu_res  input  4; alu_car, alu_of  input  1; combinational ALU results, valid in the cycle operands are driven.
REQ-011 SHALL: rsp_valid  output  1  response available.
REQ-012 SHALL: rsp_id  output  1  requester that owns the response.
REQ-013 SHALL: rsp_res  output  4; rsp_car, rsp_of  output  1; captured results.
REQ-014 SHALL: rsp_ready  input  1  consumer takes the response.

Function
REQ-015 SHALL: FSM states IDLE, EXEC, RESP; encoding free.
REQ-016 SHALL: in IDLE, grant exactly one valid requester; reqN_ready = (state==IDLE) & grantN, combinational.
REQ-017 SHALL: if only one requester is valid, it is granted regardless of priority pointer.
REQ-018 SHALL: if both are valid, the requester named by rr_ptr is granted.
REQ-019 SHALL: on every grant, rr_ptr is set to the non-granted index; rr_ptr is unchanged when no grant occurs.
REQ-020 SHALL: on grant, latch a, b, ctrl and the requester index; transition IDLE->EXEC.
REQ-021 SHALL: in EXEC, drive alu_a/alu_b/alu_ctrl from latched values with alu_go=1; at the cycle end, capture alu_res/car/of into rsp_* and transition EXEC->RESP.
REQ-022 SHALL: in RESP, assert rsp_valid; rsp_* stays stable until rsp_ready=1, then transition RESP->IDLE.
REQ-023 SHALL: latency is 2 cycles: accept in cycle N, rsp_valid first high in cycle N+2.
REQ-024 SHALL: a new grant cannot occur in the cycle rsp_ready is sampled; the next grant is at the earliest in the following IDLE cycle (throughput 1 op / 3 cycles).
REQ-025 SHALL: outside EXEC, alu_go=0 and alu_a/alu_b/alu_ctrl hold their last latched values.
REQ-026 SHALL: requests arriving in EXEC/RESP see reqN_ready=0 and are not lost; the requester holds valid.
REQ-027 SHALL: rsp_ready asserted outside RESP is ignored.

Reset
REQ-028 SHALL: rst_n=0 forces state IDLE, rr_ptr=0, and all registered outputs to 0 (alu_a, alu_b, alu_ctrl, alu_go, rsp_valid, rsp_id, rsp_res, rsp_car, rsp_of).
REQ-029 SHALL: reset during EXEC or RESP discards the in-flight operation; no response is issued after release.
REQ-030 SHALL: in the first cycle after release with both valid, requester 0 is granted.

Configuration
REQ-031 SHALL: with macro ALU_ARB_STATS_EN defined, add outputs gnt_cnt0, gnt_cnt1 (8 bits each).
- Each counter increments on a grant to its requester.
- Each counter saturates at 255.
- Both counters reset to 0.
REQ-032 SHALL: without ALU_ARB_STATS_EN, these ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 SHALL: single op: req0 a=3, b=4, ctrl=000 at cycle N; ALU model returns 7 -> req0_ready=1 at N; rsp_valid, rsp_id=0, rsp_res=7 at N+2.
REQ-034 SHALL: contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-035 SHALL: backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable; req1_ready=0 throughout; after rsp_ready=1, the next grant occurs one cycle later.
REQ-036 SHALL: reset in EXEC: assert rst_n=0 mid-op -> all outputs 0 immediately; no rsp_valid after release; first grant goes to 0.
REQ-037 SHALL: flags: req1 a=7, b=1, ctrl=000; ALU returns res=8, of=1 -> rsp_of=1, rsp_car=0, rsp_id=1.
REQ-038 SHALL: ALU_ARB_STATS_EN: 300 grants to req0 -> gnt_cnt0=255, gnt_cnt1 unchanged.
